// File: rtl/sweep_controller_pkg.sv
// Shared types and helpers for the X/Y sweep controller.
package sweep_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    PAUSE  = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic MODE_RASTER = 1'b0;
  localparam logic MODE_DIAG   = 1'b1;

  // A Y step closes a line: every tick in diagonal mode, only the last X step in raster mode.
  function automatic logic y_strobe(input logic mode_q, input logic x_last);
    return (mode_q == MODE_DIAG) || x_last;
  endfunction

endpackage

// File: rtl/sweep_controller_if.sv
// Control/status bundle between a host and the sweep controller.
interface sweep_controller_if #(
  parameter int N     = 8,
  parameter int DIV_W = 16
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             loop;
  logic             mode;
  logic [DIV_W-1:0] step_div;
  logic             gen_rst;
  logic             ena_x;
  logic             ena_y;
  logic             busy;
  logic             frame_done;
  logic [N-1:0]     line_count;

  modport master (
    output start, stop, pause, loop, mode, step_div,
    input  gen_rst, ena_x, ena_y, busy, frame_done, line_count
  );

  modport slave (
    input  start, stop, pause, loop, mode, step_div,
    output gen_rst, ena_x, ena_y, busy, frame_done, line_count
  );
endinterface

// File: rtl/sweep_controller_tick_prescaler.sv
// Step pacing counter: counts 0..div and wraps; tick marks the wrap cycle.
module tick_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             hold,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  localparam logic [DIV_W-1:0] ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] ZERO = {DIV_W{1'b0}};

  logic [DIV_W-1:0] count;

  assign tick = (count == div);

  // Prescaler count: cleared, held while paused, otherwise wraps at div.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= ZERO;
    end else if (hold) begin
      count <= count;
    end else if (tick) begin
      count <= ZERO;
    end else begin
      count <= count + ONE;
    end
  end
endmodule

// File: rtl/sweep_controller.sv
// Sequences the X/Y triangle generators through raster or diagonal frames.
module sweep_controller
  import sweep_pkg::*;
#(
  parameter int N     = 8,
  parameter int DIV_W = 16
) (
  input logic               clk,
  input logic               rst,
  sweep_controller_if.slave bus
);
  localparam logic [N-1:0]     LAST   = {{(N-1){1'b1}}, 1'b0};
  localparam logic [N-1:0]     N_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]     N_ZERO = {N{1'b0}};
  localparam logic [DIV_W-1:0] D_ZERO = {DIV_W{1'b0}};

  state_t           state;
  logic [DIV_W-1:0] div_q;
  logic             mode_q;
  logic             loop_q;
  logic [N-1:0]     x_steps;
  logic [N-1:0]     lines;

  logic tick;
  logic presc_clear;
  logic presc_hold;
  logic step;
  logic line_end;
  logic frame_end;

  assign presc_clear = (state != RUN) && (state != PAUSE);
  assign presc_hold  = (state == PAUSE);
  assign step        = (state == RUN) && tick;
  assign line_end    = y_strobe(mode_q, x_steps == LAST);
  assign frame_end   = step && line_end && (lines == LAST);

  tick_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .clear (presc_clear),
    .hold  (presc_hold),
    .div   (div_q),
    .tick  (tick)
  );

  // Sweep FSM with latched configuration and step/line counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_q   <= D_ZERO;
      mode_q  <= MODE_RASTER;
      loop_q  <= 1'b0;
      x_steps <= N_ZERO;
      lines   <= N_ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state   <= CLEAR;
            div_q   <= bus.step_div;
            mode_q  <= bus.mode;
            loop_q  <= bus.loop;
            x_steps <= N_ZERO;
            lines   <= N_ZERO;
          end
        end
        CLEAR: begin
          state <= bus.stop ? IDLE : RUN;
        end
        RUN: begin
          if (bus.stop) begin
            state <= IDLE;
          end else begin
            if (step) begin
              if (line_end) begin
                x_steps <= N_ZERO;
                lines   <= lines + N_ONE;
              end else begin
                x_steps <= x_steps + N_ONE;
              end
            end
            // A completed frame wins over a same-cycle pause request.
            if (frame_end) begin
              state <= FINISH;
            end else if (bus.pause) begin
              state <= PAUSE;
            end
          end
        end
        PAUSE: begin
          if (bus.stop) begin
            state <= IDLE;
          end else if (!bus.pause) begin
            state <= RUN;
          end
        end
        FINISH: begin
          // Looping frames continue without clearing the generators.
          x_steps <= N_ZERO;
          lines   <= N_ZERO;
          state   <= (loop_q && !bus.stop) ? RUN : IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gen_rst    = (state == CLEAR);
  assign bus.ena_x      = step;
  assign bus.ena_y      = step && line_end;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = (state == FINISH);
  assign bus.line_count = lines;
endmodule

// File: tb/tb_sweep_controller.sv
// Self-checking bench: directed scenarios plus randomized control traffic against a step-count model.
module tb_sweep_controller;
  localparam int N     = 3;
  localparam int DIV_W = 16;
  localparam int LINE  = 7;

  localparam int M_IDLE  = 0;
  localparam int M_CLR   = 1;
  localparam int M_RUN   = 2;
  localparam int M_PAUSE = 3;
  localparam int M_DONE  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sweep_controller_if #(.N(N), .DIV_W(DIV_W)) bus ();
  sweep_controller #(.N(N), .DIV_W(DIV_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // model: phase, strobes completed in this frame, cycles to next strobe
  int ph, m_steps, m_wait, m_div;
  bit m_diag, m_loop;

  int cyc = 0;
  int cnt_ex, cnt_ey, cnt_fd, cnt_gr;
  int first_ex, last_ex, gr_cyc, last_fd, fd_gap, min_gap, max_gap;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int frame_len();
    return m_diag ? LINE : LINE * LINE;
  endfunction

  function automatic void model_edge();
    if (rst) begin
      ph = M_IDLE; m_steps = 0; m_wait = 0; m_div = 0; m_diag = 1'b0; m_loop = 1'b0;
    end else begin
      case (ph)
        M_IDLE: if (bus.start && !bus.stop) begin
          ph = M_CLR; m_div = int'(bus.step_div); m_diag = bus.mode; m_loop = bus.loop; m_steps = 0;
        end
        M_CLR: begin
          ph = bus.stop ? M_IDLE : M_RUN;
          m_wait = m_div;
        end
        M_RUN: if (bus.stop) ph = M_IDLE;
        else if (m_wait == 0) begin
          m_steps++;
          m_wait = m_div;
          if (m_steps == frame_len()) ph = M_DONE;
          else if (bus.pause) ph = M_PAUSE;
        end else begin
          m_wait--;
          if (bus.pause) ph = M_PAUSE;
        end
        M_PAUSE: if (bus.stop) ph = M_IDLE; else if (!bus.pause) ph = M_RUN;
        M_DONE: begin
          m_steps = 0;
          m_wait = m_div;
          ph = (m_loop && !bus.stop) ? M_RUN : M_IDLE;
        end
        default: ph = M_IDLE;
      endcase
    end
  endfunction

  task automatic clear_counts();
    cnt_ex = 0; cnt_ey = 0; cnt_fd = 0; cnt_gr = 0;
    first_ex = -1; last_ex = -1; gr_cyc = -1; last_fd = -1; fd_gap = 0;
    min_gap = 1 << 30; max_gap = 0;
  endtask

  task automatic tick_cycle();
    logic ex_exp, ey_exp;
    int lc_exp;
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    ex_exp = (ph == M_RUN) && (m_wait == 0);
    ey_exp = ex_exp && (m_diag || ((m_steps % LINE) == LINE - 1));
    lc_exp = m_diag ? m_steps : m_steps / LINE;
    check_eq("gen_rst", 32'(bus.gen_rst), 32'(ph == M_CLR));
    check_eq("ena_x", 32'(bus.ena_x), 32'(ex_exp));
    check_eq("ena_y", 32'(bus.ena_y), 32'(ey_exp));
    check_eq("busy", 32'(bus.busy), 32'(ph != M_IDLE));
    check_eq("frame_done", 32'(bus.frame_done), 32'(ph == M_DONE));
    check_eq("line_count", 32'(bus.line_count), 32'(lc_exp));
    if (bus.ena_x === 1'b1) begin
      cnt_ex++;
      if (first_ex < 0) first_ex = cyc;
      if (last_ex >= 0) begin
        if (cyc - last_ex < min_gap) min_gap = cyc - last_ex;
        if (cyc - last_ex > max_gap) max_gap = cyc - last_ex;
      end
      last_ex = cyc;
    end
    if (bus.ena_y === 1'b1) cnt_ey++;
    if (bus.gen_rst === 1'b1) begin
      cnt_gr++;
      if (gr_cyc < 0) gr_cyc = cyc;
    end
    if (bus.frame_done === 1'b1) begin
      cnt_fd++;
      if (last_fd >= 0) fd_gap = cyc - last_fd;
      last_fd = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick_cycle();
  endtask

  task automatic kick(input logic m, input logic l, input int d);
    bus.mode = m; bus.loop = l; bus.step_div = DIV_W'(d); bus.start = 1'b1;
    tick_cycle();
    bus.start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    bus.loop = 1'b0; bus.mode = 1'b0; bus.step_div = '0;
    clear_counts();
    run(2);
    rst = 1'b0;
    run(2);
    check_eq("reset_busy", 32'(bus.busy), 32'd0);

    // raster single frame, every cycle
    clear_counts();
    kick(1'b0, 1'b0, 0);
    run(60);
    check_eq("t1_ena_x", cnt_ex, 49);
    check_eq("t1_ena_y", cnt_ey, 7);
    check_eq("t1_frame_done", cnt_fd, 1);
    check_eq("t1_gen_rst", cnt_gr, 1);
    check_eq("t1_gap", max_gap, 1);

    // prescaler spacing
    clear_counts();
    kick(1'b0, 1'b0, 2);
    run(160);
    check_eq("t2_first_ex", first_ex - gr_cyc, 3);
    check_eq("t2_min_gap", min_gap, 3);
    check_eq("t2_max_gap", max_gap, 3);
    check_eq("t2_ena_x", cnt_ex, 49);

    // diagonal single frame
    clear_counts();
    kick(1'b1, 1'b0, 0);
    run(12);
    check_eq("t3_ena_x", cnt_ex, 7);
    check_eq("t3_ena_y", cnt_ey, 7);
    check_eq("t3_frame_done", cnt_fd, 1);
    check_eq("t3_busy", 32'(bus.busy), 32'd0);

    // pause mid-line at x_steps=3
    kick(1'b0, 1'b0, 0);
    run(10);
    bus.pause = 1'b1;
    clear_counts();
    run(10);
    check_eq("t4_pause_strobes", cnt_ex, 0);
    bus.pause = 1'b0;
    clear_counts();
    for (int i = 0; i < 20 && cnt_ey == 0; i++) tick_cycle();
    check_eq("t4_resume_steps", cnt_ex, 4);
    bus.stop = 1'b1; tick_cycle(); bus.stop = 1'b0;

    // looping frames, then stop
    clear_counts();
    kick(1'b0, 1'b1, 0);
    run(159);
    check_eq("t5_frame_done", cnt_fd, 3);
    check_eq("t5_period", fd_gap, 50);
    check_eq("t5_gen_rst", cnt_gr, 1);
    bus.stop = 1'b1; tick_cycle(); bus.stop = 1'b0;
    check_eq("t5_stop_busy", 32'(bus.busy), 32'd0);
    run(3);
    check_eq("t5_stop_no_done", cnt_fd, 3);

    // reset mid-frame at line_count=4
    kick(1'b0, 1'b0, 0);
    run(29);
    check_eq("t6_line_count", 32'(bus.line_count), 32'd4);
    rst = 1'b1; tick_cycle(); rst = 1'b0;
    check_eq("t6_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("t6_rst_lc", 32'(bus.line_count), 32'd0);
    clear_counts();
    kick(1'b0, 1'b0, 0);
    check_eq("t6_restart_gen_rst", cnt_gr, 1);
    bus.stop = 1'b1; tick_cycle(); bus.stop = 1'b0;

    // randomized control traffic
    for (int s = 0; s < 40; s++) begin
      kick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      for (int i = 0, len = int'($urandom_range(20, 250)); i < len; i++) begin
        if ($urandom_range(0, 9) == 0) bus.pause = ~bus.pause;
        bus.stop     = ($urandom_range(0, 199) == 0);
        rst          = ($urandom_range(0, 299) == 0);
        bus.start    = ($urandom_range(0, 39) == 0);
        bus.mode     = 1'($urandom_range(0, 1));
        bus.loop     = 1'($urandom_range(0, 1));
        bus.step_div = DIV_W'($urandom_range(0, 3));
        tick_cycle();
      end
      rst = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
      bus.stop = 1'b1; tick_cycle(); bus.stop = 1'b0;
      tick_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
